conv_layer_sequencer: RTL and testbench

Layer-level scheduler that drives the on-chip FIFO memory dataflow controller state machine through a complete convolution layer. It loops over output filters and, within each filter, over input passes. For each filter it requests a weight load. For each pass it issues start, stop/resume and finish commands, waits for the routine-finished indication and acknowledges it. It sits between the host/top-level control registers and the dataflow controller, and is the only block that drives that controller's command inputs.

---
 rtl/conv_layer_sequencer_pkg.sv | 33 +++
 rtl/conv_layer_sequencer_if.sv | 49 ++++
 rtl/conv_seq_index_counter.sv | 22 ++
 rtl/conv_layer_sequencer.sv | 157 +++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_layer_sequencer_pkg.sv
// Shared types and defaults for the convolution layer sequencer.
// State codes are 4-bit; CONV_LAYER_SEQUENCER_PAUSE_EN enables the PAUSED/RESUME states.
package conv_layer_sequencer_pkg;

   localparam int FILTER_W_DEF  = 8;
   localparam int PASS_W_DEF    = 8;
   localparam int PAUSE_MIN_DEF = 4;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_LOAD_W = 4'd1;
   localparam logic [3:0] S_START  = 4'd2;
   localparam logic [3:0] S_RUN    = 4'd3;
   localparam logic [3:0] S_PAUSED = 4'd4;
   localparam logic [3:0] S_RESUME = 4'd5;
   localparam logic [3:0] S_FINISH = 4'd6;
   localparam logic [3:0] S_ACK    = 4'd7;
   localparam logic [3:0] S_NEXT   = 4'd8;
   localparam logic [3:0] S_DONE   = 4'd9;

   typedef enum logic [3:0] {
      ST_IDLE   = S_IDLE,
      ST_LOAD_W = S_LOAD_W,
      ST_START  = S_START,
      ST_RUN    = S_RUN,
      ST_PAUSED = S_PAUSED,
      ST_RESUME = S_RESUME,
      ST_FINISH = S_FINISH,
      ST_ACK    = S_ACK,
      ST_NEXT   = S_NEXT,
      ST_DONE   = S_DONE
   } state_t;

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Host/dataflow-controller signal bundle of the layer sequencer.
// master = host and controller side, slave = the sequencer itself.
interface conv_layer_sequencer_if
   import conv_layer_sequencer_pkg::*;
#(
   parameter int FILTER_W = FILTER_W_DEF,
   parameter int PASS_W   = PASS_W_DEF
);
   logic                CONV_LAYER_SEQUENCER_Layer_Start;
   logic [FILTER_W-1:0] CONV_LAYER_SEQUENCER_Num_Filters;
   logic [PASS_W-1:0]   CONV_LAYER_SEQUENCER_Num_Passes;
   logic                CONV_LAYER_SEQUENCER_Weight_Load_Ack;
   logic                CONV_LAYER_SEQUENCER_Fifo_Almost_Full;
   logic                CONV_LAYER_SEQUENCER_Pass_Last_Window;
   logic                CONV_LAYER_SEQUENCER_Routine_Finished_Already;
   logic                CONV_LAYER_SEQUENCER_Weight_Load_Req;
   logic                CONV_LAYER_SEQUENCER_Start_Routine;
   logic                CONV_LAYER_SEQUENCER_Stop_Routine;
   logic                CONV_LAYER_SEQUENCER_Finish_Routine;
   logic                CONV_LAYER_SEQUENCER_Routine_Finished_Ok;
   logic [FILTER_W-1:0] CONV_LAYER_SEQUENCER_Filter_Index;
   logic [PASS_W-1:0]   CONV_LAYER_SEQUENCER_Pass_Index;
   logic                CONV_LAYER_SEQUENCER_Busy;
   logic                CONV_LAYER_SEQUENCER_Layer_Done;

   modport master (
      output CONV_LAYER_SEQUENCER_Layer_Start, CONV_LAYER_SEQUENCER_Num_Filters,
             CONV_LAYER_SEQUENCER_Num_Passes, CONV_LAYER_SEQUENCER_Weight_Load_Ack,
             CONV_LAYER_SEQUENCER_Fifo_Almost_Full, CONV_LAYER_SEQUENCER_Pass_Last_Window,
             CONV_LAYER_SEQUENCER_Routine_Finished_Already,
      input  CONV_LAYER_SEQUENCER_Weight_Load_Req, CONV_LAYER_SEQUENCER_Start_Routine,
             CONV_LAYER_SEQUENCER_Stop_Routine, CONV_LAYER_SEQUENCER_Finish_Routine,
             CONV_LAYER_SEQUENCER_Routine_Finished_Ok, CONV_LAYER_SEQUENCER_Filter_Index,
             CONV_LAYER_SEQUENCER_Pass_Index, CONV_LAYER_SEQUENCER_Busy,
             CONV_LAYER_SEQUENCER_Layer_Done
   );

   modport slave (
      input  CONV_LAYER_SEQUENCER_Layer_Start, CONV_LAYER_SEQUENCER_Num_Filters,
             CONV_LAYER_SEQUENCER_Num_Passes, CONV_LAYER_SEQUENCER_Weight_Load_Ack,
             CONV_LAYER_SEQUENCER_Fifo_Almost_Full, CONV_LAYER_SEQUENCER_Pass_Last_Window,
             CONV_LAYER_SEQUENCER_Routine_Finished_Already,
      output CONV_LAYER_SEQUENCER_Weight_Load_Req, CONV_LAYER_SEQUENCER_Start_Routine,
             CONV_LAYER_SEQUENCER_Stop_Routine, CONV_LAYER_SEQUENCER_Finish_Routine,
             CONV_LAYER_SEQUENCER_Routine_Finished_Ok, CONV_LAYER_SEQUENCER_Filter_Index,
             CONV_LAYER_SEQUENCER_Pass_Index, CONV_LAYER_SEQUENCER_Busy,
             CONV_LAYER_SEQUENCER_Layer_Done
   );
endinterface

// File: rtl/conv_seq_index_counter.sv
// Index counter with synchronous clear/enable and a flag for idx == terminal-1.
module conv_seq_index_counter #(
   parameter int W = 8
) (
   input  logic         clk_sys,
   input  logic         rst_b,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] terminal,
   output logic [W-1:0] idx,
   output logic         last
);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b)   idx <= '0;
      else if (clr) idx <= '0;
      else if (en)  idx <= idx + W'(1);
   end

   assign last = (idx == (terminal - W'(1)));

endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer scheduler: loops filters x passes and drives the dataflow controller commands.
// CONV_LAYER_SEQUENCER_PAUSE_EN adds backpressure pause/resume (PAUSED, RESUME, hold counter).
//
// state  | meaning
// IDLE   | waiting for Layer_Start
// LOAD_W | weight load requested for current filter
// START  | one-cycle start pulse for current pass
// RUN    | pass in progress
// PAUSED | stop held for backpressure (min PAUSE_MIN cycles)
// RESUME | one-cycle resume pulse
// FINISH | finish command held until controller reports finished
// ACK    | one-cycle finished acknowledge
// NEXT   | advance pass / filter indices
// DONE   | one-cycle layer-done pulse
module conv_layer_sequencer
   import conv_layer_sequencer_pkg::*;
#(
   parameter int FILTER_W  = FILTER_W_DEF,
   parameter int PASS_W    = PASS_W_DEF
`ifdef CONV_LAYER_SEQUENCER_PAUSE_EN
   , parameter int PAUSE_MIN = PAUSE_MIN_DEF
`endif
) (
   input  logic                   CONV_LAYER_SEQUENCER_Clk,
   input  logic                   CONV_LAYER_SEQUENCER_Reset,
   conv_layer_sequencer_if.slave  bus
);

   state_t              state, state_nxt;
   logic [FILTER_W-1:0] num_filters;
   logic [PASS_W-1:0]   num_passes;
   logic                pass_clr, pass_en, pass_last;
   logic                filt_clr, filt_en, filt_last;
   logic                layer_start, plw, zero_cnt;

   assign layer_start = bus.CONV_LAYER_SEQUENCER_Layer_Start;
   assign plw         = bus.CONV_LAYER_SEQUENCER_Pass_Last_Window;
   assign zero_cnt    = (bus.CONV_LAYER_SEQUENCER_Num_Filters == '0) ||
                        (bus.CONV_LAYER_SEQUENCER_Num_Passes == '0);

`ifdef CONV_LAYER_SEQUENCER_PAUSE_EN
   localparam int HOLD_W = $clog2(PAUSE_MIN);
   logic [HOLD_W-1:0] hold_cnt;
   logic              finish_pend, faf;

   assign faf = bus.CONV_LAYER_SEQUENCER_Fifo_Almost_Full;

   // hold_cnt reaches 0 in the PAUSE_MIN-th PAUSED cycle
   always_ff @(posedge CONV_LAYER_SEQUENCER_Clk or negedge CONV_LAYER_SEQUENCER_Reset) begin
      if (!CONV_LAYER_SEQUENCER_Reset) begin
         hold_cnt    <= '0;
         finish_pend <= 1'b0;
      end else begin
         if (state == ST_RUN && state_nxt == ST_PAUSED)
            hold_cnt <= HOLD_W'(PAUSE_MIN - 1);
         else if (state == ST_PAUSED && hold_cnt != '0)
            hold_cnt <= hold_cnt - HOLD_W'(1);
         if (state == ST_RESUME)
            finish_pend <= 1'b0;
         else if (state == ST_PAUSED && plw)
            finish_pend <= 1'b1;
      end
   end
`endif

   always_ff @(posedge CONV_LAYER_SEQUENCER_Clk or negedge CONV_LAYER_SEQUENCER_Reset) begin
      if (!CONV_LAYER_SEQUENCER_Reset) begin
         state       <= ST_IDLE;
         num_filters <= '0;
         num_passes  <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && layer_start) begin
            num_filters <= bus.CONV_LAYER_SEQUENCER_Num_Filters;
            num_passes  <= bus.CONV_LAYER_SEQUENCER_Num_Passes;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      pass_clr  = 1'b0;
      pass_en   = 1'b0;
      filt_clr  = 1'b0;
      filt_en   = 1'b0;
      case (state)
         ST_IDLE: if (layer_start) begin
            pass_clr  = 1'b1;
            filt_clr  = 1'b1;
            state_nxt = zero_cnt ? ST_DONE : ST_LOAD_W;
         end
         ST_LOAD_W: if (bus.CONV_LAYER_SEQUENCER_Weight_Load_Ack) state_nxt = ST_START;
         ST_START:  state_nxt = ST_RUN;
`ifdef CONV_LAYER_SEQUENCER_PAUSE_EN
         ST_RUN: begin
            if (plw)      state_nxt = ST_FINISH;
            else if (faf) state_nxt = ST_PAUSED;
         end
         ST_PAUSED: if (hold_cnt == '0 && !faf) state_nxt = ST_RESUME;
         ST_RESUME: state_nxt = finish_pend ? ST_FINISH : ST_RUN;
`else
         ST_RUN: if (plw) state_nxt = ST_FINISH;
`endif
         ST_FINISH: if (bus.CONV_LAYER_SEQUENCER_Routine_Finished_Already) state_nxt = ST_ACK;
         ST_ACK:    state_nxt = ST_NEXT;
         ST_NEXT: begin
            if (!pass_last) begin
               pass_en   = 1'b1;
               state_nxt = ST_START;
            end else begin
               pass_clr = 1'b1;
               if (!filt_last) begin
                  filt_en   = 1'b1;
                  state_nxt = ST_LOAD_W;
               end else begin
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   conv_seq_index_counter #(.W(PASS_W)) u_pass_cnt (
      .clk_sys  (CONV_LAYER_SEQUENCER_Clk),
      .rst_b    (CONV_LAYER_SEQUENCER_Reset),
      .clr      (pass_clr),
      .en       (pass_en),
      .terminal (num_passes),
      .idx      (bus.CONV_LAYER_SEQUENCER_Pass_Index),
      .last     (pass_last)
   );

   conv_seq_index_counter #(.W(FILTER_W)) u_filt_cnt (
      .clk_sys  (CONV_LAYER_SEQUENCER_Clk),
      .rst_b    (CONV_LAYER_SEQUENCER_Reset),
      .clr      (filt_clr),
      .en       (filt_en),
      .terminal (num_filters),
      .idx      (bus.CONV_LAYER_SEQUENCER_Filter_Index),
      .last     (filt_last)
   );

   assign bus.CONV_LAYER_SEQUENCER_Weight_Load_Req   = (state == ST_LOAD_W);
   assign bus.CONV_LAYER_SEQUENCER_Start_Routine     = (state == ST_START) || (state == ST_RESUME);
`ifdef CONV_LAYER_SEQUENCER_PAUSE_EN
   assign bus.CONV_LAYER_SEQUENCER_Stop_Routine      = (state == ST_PAUSED);
`else
   assign bus.CONV_LAYER_SEQUENCER_Stop_Routine      = 1'b0;
`endif
   assign bus.CONV_LAYER_SEQUENCER_Finish_Routine    = (state == ST_FINISH);
   assign bus.CONV_LAYER_SEQUENCER_Routine_Finished_Ok = (state == ST_ACK);
   assign bus.CONV_LAYER_SEQUENCER_Busy              = (state != ST_IDLE);
   assign bus.CONV_LAYER_SEQUENCER_Layer_Done        = (state == ST_DONE);

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Randomized bench for conv_layer_sequencer: a reference model queues expected command events,
// a monitor turns observed DUT outputs into events and compares them in order.
module tb_conv_layer_sequencer;
   import conv_layer_sequencer_pkg::*;

   localparam int FW   = FILTER_W_DEF;
   localparam int PW   = PASS_W_DEF;
   localparam int PMIN = PAUSE_MIN_DEF;
`ifdef CONV_LAYER_SEQUENCER_PAUSE_EN
   localparam bit PAUSE_ON = 1'b1;
`else
   localparam bit PAUSE_ON = 1'b0;
`endif

   localparam int EV_WREQ = 0, EV_START = 1, EV_STOP = 2, EV_FIN = 3, EV_OK = 4, EV_DONE = 5;

   typedef struct {
      int kind;
      int f;
      int p;
      int val;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv_layer_sequencer_if #(.FILTER_W(FW), .PASS_W(PW)) bus ();

   conv_layer_sequencer #(.FILTER_W(FW), .PASS_W(PW)) dut (
      .CONV_LAYER_SEQUENCER_Clk   (clk),
      .CONV_LAYER_SEQUENCER_Reset (rst_n),
      .bus                        (bus)
   );

   wire req   = bus.CONV_LAYER_SEQUENCER_Weight_Load_Req;
   wire start = bus.CONV_LAYER_SEQUENCER_Start_Routine;
   wire stop  = bus.CONV_LAYER_SEQUENCER_Stop_Routine;
   wire fin   = bus.CONV_LAYER_SEQUENCER_Finish_Routine;
   wire ok_o  = bus.CONV_LAYER_SEQUENCER_Routine_Finished_Ok;
   wire busy  = bus.CONV_LAYER_SEQUENCER_Busy;
   wire done  = bus.CONV_LAYER_SEQUENCER_Layer_Done;
   wire [FW-1:0] fidx = bus.CONV_LAYER_SEQUENCER_Filter_Index;
   wire [PW-1:0] pidx = bus.CONV_LAYER_SEQUENCER_Pass_Index;

   ev_t exp_q[$];
   int  vectors = 0;
   int  miscompares = 0;
   int  max_dly = 3;

   function automatic string kname(input int k);
      case (k)
         EV_WREQ:  return "weight_req";
         EV_START: return "start_pulse";
         EV_STOP:  return "stop_window";
         EV_FIN:   return "finish_cmd";
         EV_OK:    return "finished_ok";
         default:  return "layer_done";
      endcase
   endfunction

   task automatic push(input int k, input int f, input int p, input int v);
      ev_t e;
      e.kind = k; e.f = f; e.p = p; e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic observe(input int k, input int v);
      ev_t e;
      vectors++;
      if (!busy) begin
         miscompares++;
         $display("FAIL busy_during_%s: got busy=0, expected 1", kname(k));
      end
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected_%s: got f=%0d p=%0d v=%0d, expected no event", kname(k), fidx, pidx, v);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.f != int'(fidx) || e.p != int'(pidx) || e.val != v) begin
            miscompares++;
            $display("FAIL event_%s: got %s f=%0d p=%0d v=%0d, expected %s f=%0d p=%0d v=%0d",
                     kname(e.kind), kname(k), fidx, pidx, v, kname(e.kind), e.f, e.p, e.val);
         end
      end
   endtask

   initial begin
      logic p_req, p_start, p_stop, p_fin, p_ok, p_done;
      int   slen;
      p_req = 0; p_start = 0; p_stop = 0; p_fin = 0; p_ok = 0; p_done = 0; slen = 0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            p_req = 0; p_start = 0; p_stop = 0; p_fin = 0; p_ok = 0; p_done = 0; slen = 0;
         end else begin
            if (req && !p_req) observe(EV_WREQ, int'(bus.CONV_LAYER_SEQUENCER_Layer_Start));
            if (stop) slen++;
            if (!stop && p_stop) begin
               observe(EV_STOP, slen);
               slen = 0;
            end
            if (start) observe(EV_START, int'(bus.CONV_LAYER_SEQUENCER_Weight_Load_Ack));
            if (fin && !p_fin) observe(EV_FIN, int'(p_start));
            if (ok_o) observe(EV_OK, int'(bus.CONV_LAYER_SEQUENCER_Routine_Finished_Already));
            if (done) observe(EV_DONE, int'(bus.CONV_LAYER_SEQUENCER_Layer_Start));
            p_req = req; p_start = start; p_stop = stop; p_fin = fin; p_ok = ok_o; p_done = done;
         end
      end
   end

   // ---------------- driver ----------------
   function automatic bit sig_val(input int w);
      case (w)
         0:       return req;
         1:       return start;
         2:       return fin;
         default: return done;
      endcase
   endfunction

   task automatic wait_sig(input int w, input string what, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (sig_val(w)) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
      vectors++;
      miscompares++;
      $display("FAIL timeout_%s: got no assertion within 300 cycles, expected one", what);
   endtask

   task automatic clear_inputs();
      bus.CONV_LAYER_SEQUENCER_Layer_Start = 0;
      bus.CONV_LAYER_SEQUENCER_Weight_Load_Ack = 0;
      bus.CONV_LAYER_SEQUENCER_Fifo_Almost_Full = 0;
      bus.CONV_LAYER_SEQUENCER_Pass_Last_Window = 0;
      bus.CONV_LAYER_SEQUENCER_Routine_Finished_Already = 0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_wreq"}, req, 0);
      chk({tag, "_start"}, start, 0);
      chk({tag, "_stop"}, stop, 0);
      chk({tag, "_finish"}, fin, 0);
      chk({tag, "_ok"}, ok_o, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_fidx"}, int'(fidx), 0);
      chk({tag, "_pidx"}, int'(pidx), 0);
   endtask

   // asynchronous reset mid-cycle; outputs must clear without waiting for a clock edge
   task automatic hard_reset(input string tag);
      #2 rst_n = 0;
      clear_inputs();
      #1 chk_idle(tag);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   function automatic int maxi(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // scen: 0 plain, 1 backpressure, 2 last-window+backpressure together, 3 last-window while paused
   task automatic run_layer(input int nf, input int np, input int force_s, input int force_h,
                            input bit rst_at_f1);
      int sc[$], hh[$];
      int s, h, i, d;
      bit ok;
      for (int k = 0; k < nf * np; k++) begin
         s = (force_s >= 0) ? force_s : int'($urandom_range(0, 3));
         h = (force_h > 0) ? force_h : ((s == 3) ? int'($urandom_range(2, 6)) : int'($urandom_range(1, 6)));
         sc.push_back(s);
         hh.push_back(h);
      end
      if (nf == 0 || np == 0) begin
         push(EV_DONE, 0, 0, 1);
      end else begin
         for (int f = 0; f < nf; f++) begin
            push(EV_WREQ, f, 0, (f == 0) ? 1 : 0);
            for (int p = 0; p < np; p++) begin
               s = sc[f * np + p];
               push(EV_START, f, p, (p == 0) ? 1 : 0);
               if (PAUSE_ON && (s == 1 || s == 3)) begin
                  push(EV_STOP, f, p, maxi(PMIN, hh[f * np + p]));
                  push(EV_START, f, p, 0);
               end
               push(EV_FIN, f, p, (PAUSE_ON && s == 3) ? 1 : 0);
               push(EV_OK, f, p, 1);
            end
         end
         push(EV_DONE, nf - 1, 0, 0);
      end

      bus.CONV_LAYER_SEQUENCER_Num_Filters = FW'(nf);
      bus.CONV_LAYER_SEQUENCER_Num_Passes  = PW'(np);
      bus.CONV_LAYER_SEQUENCER_Layer_Start = 1;
      @(negedge clk);
      bus.CONV_LAYER_SEQUENCER_Layer_Start = 0;
      bus.CONV_LAYER_SEQUENCER_Num_Filters = FW'($urandom_range(0, 255));
      bus.CONV_LAYER_SEQUENCER_Num_Passes  = PW'($urandom_range(0, 255));

      if (nf != 0 && np != 0) begin
         i = 0;
         for (int f = 0; f < nf; f++) begin
            wait_sig(0, "weight_req", ok);
            if (!ok) begin hard_reset("recover"); return; end
            repeat ($urandom_range(0, max_dly)) @(negedge clk);
            bus.CONV_LAYER_SEQUENCER_Weight_Load_Ack = 1;
            @(negedge clk);
            bus.CONV_LAYER_SEQUENCER_Weight_Load_Ack = 0;
            for (int p = 0; p < np; p++) begin
               wait_sig(1, "start", ok);
               if (!ok) begin hard_reset("recover"); return; end
               @(negedge clk);
               s = sc[i]; h = hh[i]; i++;
               d = int'($urandom_range(0, max_dly));
               case (s)
                  0: begin
                     if ($urandom_range(0, 1) == 1) begin
                        bus.CONV_LAYER_SEQUENCER_Layer_Start = 1;
                        bus.CONV_LAYER_SEQUENCER_Num_Filters = FW'($urandom_range(0, 3));
                        bus.CONV_LAYER_SEQUENCER_Num_Passes  = PW'($urandom_range(0, 3));
                        @(negedge clk);
                        bus.CONV_LAYER_SEQUENCER_Layer_Start = 0;
                     end
                     repeat (d) @(negedge clk);
                  end
                  1: begin
                     bus.CONV_LAYER_SEQUENCER_Fifo_Almost_Full = 1;
                     repeat (h) @(negedge clk);
                     bus.CONV_LAYER_SEQUENCER_Fifo_Almost_Full = 0;
`ifdef CONV_LAYER_SEQUENCER_PAUSE_EN
                     wait_sig(1, "resume", ok);
                     if (!ok) begin hard_reset("recover"); return; end
                     @(negedge clk);
`endif
                     repeat (d) @(negedge clk);
                  end
                  default: ;
               endcase
               if (s == 2) begin
                  bus.CONV_LAYER_SEQUENCER_Fifo_Almost_Full = 1;
                  bus.CONV_LAYER_SEQUENCER_Pass_Last_Window = 1;
                  @(negedge clk);
                  bus.CONV_LAYER_SEQUENCER_Fifo_Almost_Full = 0;
                  bus.CONV_LAYER_SEQUENCER_Pass_Last_Window = 0;
               end else if (s == 3) begin
                  bus.CONV_LAYER_SEQUENCER_Fifo_Almost_Full = 1;
                  @(negedge clk);
                  bus.CONV_LAYER_SEQUENCER_Pass_Last_Window = 1;
                  @(negedge clk);
                  bus.CONV_LAYER_SEQUENCER_Pass_Last_Window = 0;
                  repeat (h - 2) @(negedge clk);
                  bus.CONV_LAYER_SEQUENCER_Fifo_Almost_Full = 0;
               end else begin
                  bus.CONV_LAYER_SEQUENCER_Pass_Last_Window = 1;
                  @(negedge clk);
                  bus.CONV_LAYER_SEQUENCER_Pass_Last_Window = 0;
               end
               wait_sig(2, "finish", ok);
               if (!ok) begin hard_reset("recover"); return; end
               if (rst_at_f1 && f == 1) begin
                  chk("pre_reset_fidx", int'(fidx), 1);
                  hard_reset("reset_in_finish");
                  return;
               end
               repeat ($urandom_range(0, max_dly)) @(negedge clk);
               bus.CONV_LAYER_SEQUENCER_Routine_Finished_Already = 1;
               @(negedge clk);
               bus.CONV_LAYER_SEQUENCER_Routine_Finished_Already = 0;
            end
         end
      end
      wait_sig(3, "layer_done", ok);
      if (!ok) begin hard_reset("recover"); return; end
      @(negedge clk);
      chk("busy_after_done", busy, 0);
   endtask

   initial begin
      int nf, np;
      clear_inputs();
      bus.CONV_LAYER_SEQUENCER_Num_Filters = '0;
      bus.CONV_LAYER_SEQUENCER_Num_Passes  = '0;
      rst_n = 0;
      repeat (2) @(negedge clk);
      chk_idle("reset");
      rst_n = 1;
      @(negedge clk);

      max_dly = 0;
      run_layer(2, 3, 0, 1, 1'b0);
      max_dly = 3;
      run_layer(2, 0, 0, 1, 1'b0);
      run_layer(0, 3, 0, 1, 1'b0);
      run_layer(1, 1, 1, 1, 1'b0);
      run_layer(1, 1, 2, 1, 1'b0);
      run_layer(1, 2, 3, 3, 1'b0);
      run_layer(2, 1, 0, 1, 1'b1);
      run_layer(1, 2, 0, 1, 1'b0);

      for (int n = 0; n < 14; n++) begin
         nf = int'($urandom_range(1, 3));
         np = int'($urandom_range(1, 3));
         if ($urandom_range(0, 6) == 0) np = 0;
         run_layer(nf, np, -1, 0, 1'b0);
      end

      repeat (3) @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL leftover_events: got %0d unobserved, expected 0 (next %s f=%0d p=%0d)",
                  exp_q.size(), kname(exp_q[0].kind), exp_q[0].f, exp_q[0].p);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
